riscv_program_loader: RTL

- Writer side of the instruction-memory interface. The datapath only reads instruction memory; this block fills it.
- Receives a framed byte stream (valid/ready) from a host link, for example a UART receiver.
- Assembles little-endian 32-bit instruction words, writes them sequentially into instruction memory, and validates a checksum.
- Holds the core in reset (`core_hold`) until a program has loaded successfully.

---
 rtl/riscv_program_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/riscv_program_loader.sv
// riscv_program_loader: writes a framed, checksummed byte stream into instruction memory
//   clk        : system clock, rising-edge
//   a_rst      : asynchronous active-high reset
//   start      : one-cycle pulse arming the loader for a new frame (ignored while busy)
//   in_data    : stream byte, transferred when in_valid && in_ready
//   in_valid   : in_data holds a byte
//   in_ready   : loader accepts a byte this cycle
//   mem_w_en   : one-cycle write strobe per assembled word
//   mem_w_addr : byte address of the word being written
//   mem_w_data : assembled little-endian instruction word
//   core_hold  : holds the core in reset until a frame loads successfully
//   busy       : a frame is in progress
//   done       : sticky, last frame loaded with matching checksum
//   error      : sticky, last frame rejected
module riscv_program_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WORDS  = 64,
    parameter int START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  a_rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [31:0]           mem_w_data,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int WI = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;

    state_t        state;
    logic [15:0]   len;
    logic [WI-1:0] word_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    sum;
    logic [23:0]   word;
    logic          xfer;
    logic [15:0]   len_full;

    assign xfer     = in_valid && in_ready;
    assign len_full = {in_data, len[7:0]};

    // in_ready and busy are registered, so they are updated together with
    // every transition into or out of the byte-accepting states.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            mem_w_en   <= 1'b0;
            mem_w_addr <= ADDR_WIDTH'(START_ADDR);
            mem_w_data <= 32'd0;
            core_hold  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            len        <= 16'd0;
            word_idx   <= '0;
            byte_idx   <= 2'd0;
            sum        <= 8'd0;
            word       <= 24'd0;
        end else begin
            mem_w_en <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state     <= LEN_LO;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        core_hold <= 1'b1;
                        word_idx  <= '0;
                        byte_idx  <= 2'd0;
                        sum       <= 8'd0;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= in_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= in_data;
                        if (len_full > 16'(MAX_WORDS)) begin
                            state    <= ERROR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            state <= (len_full == 16'd0) ? CHECK : DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        sum      <= sum + in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // Fourth byte completes the word; write it straight from the input.
                            mem_w_en   <= 1'b1;
                            mem_w_addr <= ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'({word_idx, 2'b00});
                            mem_w_data <= {in_data, word};
                            word_idx   <= word_idx + WI'(1);
                            if (16'(word_idx) == len - 16'd1)
                                state <= CHECK;
                        end else begin
                            word[{byte_idx, 3'b000} +: 8] <= in_data;
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == sum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
